// File: rtl/popcount_pkg.sv
// Shared constants, mode encoding and elaboration-time helpers for the popcount pipeline.
package popcount_pkg;

    localparam int unsigned DEFAULT_ACC_W = 16;

    typedef enum logic {
        MODE_BEAT  = 1'b0,
        MODE_GROUP = 1'b1
    } mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Element count entering tree level `level` (level 0 = raw input bits).
    function automatic int unsigned tree_elems(input int unsigned width, input int unsigned level);
        int unsigned n;
        n = width;
        for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Bit offset of a level's slice in the flattened tree bus; elements of level j are j+1 bits wide.
    function automatic int unsigned tree_offset(input int unsigned width, input int unsigned level);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < level; j++) off += tree_elems(width, j) * (j + 1);
        return off;
    endfunction

endpackage

// File: rtl/popcount_level.sv
// One registered adder-tree level: sums adjacent element pairs, passes an odd element through widened.
module popcount_level
    import popcount_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned EW_IN = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_hold,
    input  logic                                   i_valid,
    input  logic                                   i_mode,
    input  logic                                   i_last,
    input  logic [N_IN*EW_IN-1:0]                  i_data,
    output logic                                   o_valid,
    output logic                                   o_mode,
    output logic                                   o_last,
    output logic [((N_IN+1)/2)*(EW_IN+1)-1:0]      o_data
);

    localparam int unsigned N_OUT  = (N_IN + 1) / 2;
    localparam int unsigned EW_OUT = EW_IN + 1;

    logic [N_OUT*EW_OUT-1:0] w_sum;
    logic [N_OUT*EW_OUT-1:0] r_data;
    logic                    r_valid;
    logic                    r_mode;
    logic                    r_last;

    for (genvar g = 0; g < N_OUT; g++) begin : g_pair
        if (2 * g + 1 < N_IN) begin : g_add
            assign w_sum[g*EW_OUT +: EW_OUT] = EW_OUT'(i_data[2*g*EW_IN +: EW_IN])
                                             + EW_OUT'(i_data[(2*g+1)*EW_IN +: EW_IN]);
        end else begin : g_pass
            assign w_sum[g*EW_OUT +: EW_OUT] = EW_OUT'(i_data[2*g*EW_IN +: EW_IN]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_last  <= 1'b0;
        end else if (!i_hold) begin
            r_data  <= w_sum;
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_last  <= i_last;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_last  = r_last;

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined population count with per-beat or saturating group-accumulate output,
// valid/ready handshake on both sides and a whole-pipe stall on output backpressure.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int unsigned CNT_W     = clog2(WIDTH + 1);
    localparam int unsigned LEVELS    = clog2(WIDTH);
    localparam int unsigned TREE_BITS = tree_offset(WIDTH, LEVELS + 1);
    localparam int unsigned TAIL_OFF  = tree_offset(WIDTH, LEVELS);
    localparam int unsigned TAIL_W    = LEVELS + 1;
    localparam int unsigned ACC_W1    = ACC_W + 1;

    // Level k occupies its own slice of w_tree; slot 0 is the gated input beat.
    logic [TREE_BITS-1:0] w_tree;
    logic [LEVELS:0]      w_valid;
    logic [LEVELS:0]      w_mode;
    logic [LEVELS:0]      w_last;

    logic                 w_stall;
    logic                 w_accept;
    logic [TAIL_W-1:0]    w_tail;
    logic [CNT_W-1:0]     w_count;
    logic [ACC_W:0]       w_count_ext;
    logic [ACC_W:0]       w_sum;
    logic                 w_sat;
    logic [ACC_W-1:0]     w_acc_next;

    logic                 r_out_valid;
    logic [ACC_W-1:0]     r_out_count;
    logic                 r_out_ovf;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_acc_ovf;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;

    // Unaccepted beats enter as zeroed bubbles so nothing undefined reaches the accumulator.
    assign w_tree[0 +: WIDTH] = w_accept ? in_data : '0;
    assign w_valid[0]         = w_accept;
    assign w_mode[0]          = w_accept & in_mode;
    assign w_last[0]          = w_accept & in_mode & in_last;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int unsigned IN_OFF   = tree_offset(WIDTH, k);
        localparam int unsigned IN_BITS  = tree_elems(WIDTH, k) * (k + 1);
        localparam int unsigned OUT_OFF  = tree_offset(WIDTH, k + 1);
        localparam int unsigned OUT_BITS = tree_elems(WIDTH, k + 1) * (k + 2);

        popcount_level #(
            .N_IN  (tree_elems(WIDTH, k)),
            .EW_IN (k + 1)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_hold  (w_stall),
            .i_valid (w_valid[k]),
            .i_mode  (w_mode[k]),
            .i_last  (w_last[k]),
            .i_data  (w_tree[IN_OFF +: IN_BITS]),
            .o_valid (w_valid[k+1]),
            .o_mode  (w_mode[k+1]),
            .o_last  (w_last[k+1]),
            .o_data  (w_tree[OUT_OFF +: OUT_BITS])
        );
    end

    assign w_tail      = w_tree[TAIL_OFF +: TAIL_W];
    assign w_count     = CNT_W'(w_tail);
    assign w_count_ext = ACC_W1'(w_count);
    assign w_sum       = {1'b0, r_acc} + w_count_ext;
    assign w_sat       = w_sum[ACC_W];
    assign w_acc_next  = w_sat ? '1 : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= 1'b0;
            if (w_valid[LEVELS]) begin
                if (mode_e'(w_mode[LEVELS]) == MODE_BEAT) begin
                    r_out_valid <= 1'b1;
                    r_out_count <= ACC_W'(w_count);
                    r_out_ovf   <= 1'b0;
                end else if (w_last[LEVELS]) begin
                    r_out_valid <= 1'b1;
                    r_out_count <= w_acc_next;
                    r_out_ovf   <= r_acc_ovf | w_sat;
                    r_acc       <= '0;
                    r_acc_ovf   <= 1'b0;
                end else begin
                    r_acc     <= w_acc_next;
                    r_acc_ovf <= r_acc_ovf | w_sat;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench: WIDTH=7/ACC_W=16 (a), WIDTH=7/ACC_W=4 (b), WIDTH=1 (c) sharing handshake inputs.
module tb_popcount_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_mode = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [6:0]  in_data = '0;
    logic        d1 = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [15:0] a_out_count;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [3:0]  b_out_count;
    logic        c_in_ready, c_out_valid, c_out_ovf;
    logic [15:0] c_out_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    popcount_pipe #(.WIDTH(7), .ACC_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    popcount_pipe #(.WIDTH(7), .ACC_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    popcount_pipe #(.WIDTH(1), .ACC_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(d1), .in_mode(in_mode), .in_last(in_last),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_count(c_out_count), .out_ovf(c_out_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic vld(input int sel);
        case (sel)
            0:       return a_out_valid;
            1:       return b_out_valid;
            default: return c_out_valid;
        endcase
    endfunction

    function automatic logic [31:0] cnt(input int sel);
        case (sel)
            0:       return {16'd0, a_out_count};
            1:       return {28'd0, b_out_count};
            default: return {16'd0, c_out_count};
        endcase
    endfunction

    function automatic logic ovf(input int sel);
        case (sel)
            0:       return a_out_ovf;
            1:       return b_out_ovf;
            default: return c_out_ovf;
        endcase
    endfunction

    task automatic send(input logic [6:0] d, input logic m, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic quiet(input int sel, input int n, input string tag);
        repeat (n) begin
            chk(tag, {31'd0, vld(sel)}, 32'd0);
            tick();
        end
    endtask

    task automatic beat(input int sel, input int exp_cnt, input logic exp_ovf, input string tag);
        chk({tag, "_valid"}, {31'd0, vld(sel)}, 32'd1);
        chk({tag, "_count"}, cnt(sel), exp_cnt);
        chk({tag, "_ovf"},   {31'd0, ovf(sel)}, {31'd0, exp_ovf});
        tick();
    endtask

    logic [6:0] s_data [10] = '{7'h7F, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h00, 7'h55, 7'h2A};
    int         s_exp  [10] = '{7, 1, 2, 3, 4, 5, 6, 0, 4, 3};

    initial begin
        int sent;
        int rcvd;

        // Reset state, with a beat presented and backpressure asserted during reset
        #2;
        in_valid  = 1'b1;
        in_data   = 7'h7F;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_count", {16'd0, a_out_count}, 32'd0);
        chk("rst_out_ovf",   {31'd0, a_out_ovf},   32'd0);
        chk("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        tick();
        tick();
        chk("rst_hold_valid", {31'd0, a_out_valid}, 32'd0);
        idle();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        quiet(0, 5, "rst_dropped_beat");

        // Mode 0 latency and values
        send(7'h7F, 1'b0, 1'b0);
        chk("lat_c1", {31'd0, a_out_valid}, 32'd0);
        send(7'h00, 1'b0, 1'b0);
        chk("lat_c2", {31'd0, a_out_valid}, 32'd0);
        send(7'h55, 1'b0, 1'b0);
        idle();
        quiet(0, 1, "lat_c3");
        beat(0, 7, 1'b0, "m0_7f");
        beat(0, 0, 1'b0, "m0_00");
        beat(0, 4, 1'b0, "m0_55");
        quiet(0, 1, "m0_after");

        // Mode 1 group: 4 + 2 + 7
        send(7'h0F, 1'b1, 1'b0);
        send(7'h03, 1'b1, 1'b0);
        send(7'h7F, 1'b1, 1'b1);
        idle();
        quiet(0, 3, "grp_bubble");
        beat(0, 13, 1'b0, "grp_13");
        quiet(0, 1, "grp_after");
        send(7'h01, 1'b1, 1'b1);
        idle();
        quiet(0, 3, "grp2_bubble");
        beat(0, 1, 1'b0, "grp2_1");

        // Mode 0 stream with 5 cycles of output backpressure
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 6 && c < 11);
            if (sent < 10) begin
                in_valid = 1'b1;
                in_data  = s_data[sent];
                in_mode  = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 4 && c < 14)
                chk("stall_in_ready", {31'd0, a_in_ready}, (c >= 6 && c < 11) ? 32'd0 : 32'd1);
            if (a_out_valid && out_ready) begin
                if (rcvd < 10) chk("stall_order", {16'd0, a_out_count}, s_exp[rcvd]);
                rcvd++;
            end
            if (sent < 10 && a_in_ready) sent++;
            tick();
        end
        chk("stall_received", rcvd, 32'd10);
        idle();
        out_ready = 1'b1;

        // Saturation on ACC_W=4 (b); a accumulates the same beats unsaturated
        send(7'h7F, 1'b1, 1'b0);
        send(7'h7F, 1'b1, 1'b0);
        send(7'h7F, 1'b1, 1'b1);
        idle();
        quiet(1, 3, "sat_bubble");
        chk("sat_wide_count", {16'd0, a_out_count}, 32'd21);
        chk("sat_wide_ovf",   {31'd0, a_out_ovf},   32'd0);
        beat(1, 15, 1'b1, "sat_15");
        send(7'h01, 1'b1, 1'b1);
        idle();
        quiet(1, 3, "sat_next_bubble");
        beat(1, 1, 1'b0, "sat_next");

        // Reset with an open group holding acc=4
        send(7'h0F, 1'b1, 1'b0);
        idle();
        quiet(0, 4, "open_grp");
        in_valid = 1'b1;
        in_data  = 7'h7F;
        in_mode  = 1'b1;
        in_last  = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, a_out_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, a_in_ready},  32'd1);
        tick();
        chk("mid_rst_valid2", {31'd0, a_out_valid}, 32'd0);
        idle();
        rst_n = 1'b1;
        send(7'h01, 1'b1, 1'b1);
        idle();
        quiet(0, 3, "post_rst_bubble");
        beat(0, 1, 1'b0, "post_rst_grp");

        // WIDTH=1 build (c): single-cycle latency
        in_mode  = 1'b0;
        in_last  = 1'b0;
        in_valid = 1'b1;
        d1 = 1'b1; tick();
        chk("w1_v0", {31'd0, c_out_valid}, 32'd1);
        chk("w1_c0", {16'd0, c_out_count}, 32'd1);
        d1 = 1'b0; tick();
        chk("w1_v1", {31'd0, c_out_valid}, 32'd1);
        chk("w1_c1", {16'd0, c_out_count}, 32'd0);
        d1 = 1'b1; tick();
        chk("w1_c2", {16'd0, c_out_count}, 32'd1);
        in_valid = 1'b0; tick();
        chk("w1_idle", {31'd0, c_out_valid}, 32'd0);
        in_mode  = 1'b1;
        in_valid = 1'b1;
        d1 = 1'b1; tick();
        chk("w1_acc_b0", {31'd0, c_out_valid}, 32'd0);
        tick();
        chk("w1_acc_b1", {31'd0, c_out_valid}, 32'd0);
        in_last = 1'b1; tick();
        idle();
        chk("w1_acc_v", {31'd0, c_out_valid}, 32'd1);
        chk("w1_acc_c", {16'd0, c_out_count}, 32'd3);
        tick();
        chk("w1_acc_after", {31'd0, c_out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
